spi_flash_fetch_ctrl: RTL and testbench
=======================================

Name: spi_flash_fetch_ctrl

Overview:
Parametrised instruction-fetch bridge between the CPU handshake port and the SPI controller on the interconnect. On a miss it fetches a whole line of LINE_WORDS 32-bit words from SPI flash in one SPI transaction, then holds the line in a single-line buffer. Reads that hit the buffer return in one cycle. It is the successor of the single-word boot fetcher, adding burst lines, 3- or 4-byte addressing and a flush input.

Parameters:
ADDR_BYTES, 3, flash address bytes; 3 selects command 0x03, 4 selects command 0x13.
LINE_WORDS, 2, words per line; power of two, 1..8.
SPI_BASE, 32'h10200, SPI controller base address. Register offsets: CR +0x00, DTR +0x08, DRR +0x0C, RX occupancy +0x14.
FIFO_DEPTH, 16, SPI FIFO depth in bytes. Elaboration error if TOTAL = 1 + ADDR_BYTES + DUMMY + 4*LINE_WORDS exceeds FIFO_DEPTH.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  single-cycle pulse; invalidates the line buffer
cpu_hs_read_i  in  1  fetch request; held high until ready
cpu_hs_addr_i  in  32  byte address; bits [1:0] ignored
cpu_hs_ready_o  out  1  one-cycle completion pulse
cpu_hs_data_o  out  32  fetched word; valid while ready is high
bus_hs_ready_i  in  1  interconnect access complete
bus_hs_data_i  in  32  interconnect read data
bus_hs_rd_o  out  1  interconnect read request
bus_hs_wr_o  out  1  interconnect write request
bus_hs_addr_o  out  32  interconnect address
bus_hs_data_o  out  32  interconnect write data
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-low): state IDLE, buffer valid=0, counters 0. All outputs 0.
- Bus accesses:
  - rd/wr, addr and data are held stable until a cycle in which bus_hs_ready_i=1; that cycle completes the access.
  - Back-to-back accesses are allowed.
  - rd and wr are never both high.
  - When no access is active, addr and data are driven to 0.
- Line arithmetic:
  - line address = cpu_hs_addr_i[8*ADDR_BYTES-1:0] with the low log2(4*LINE_WORDS) bits cleared.
  - Hit when valid=1 and the tag equals cpu_hs_addr_i[8*ADDR_BYTES-1:log2(4*LINE_WORDS)].
- State machine:
  - IDLE: on read with a hit, go to RESPOND. On read with a miss, latch the line address and go to SET_INH.
  - SET_INH: write 0x4 to CR; clear the byte counter.
  - TX_FILL: write one byte per access to DTR, TOTAL accesses in this order: command byte, address bytes MSB first, DUMMY zero bytes, then 4*LINE_WORDS bytes of 0x00.
  - CLR_INH: write 0x0 to CR; clear the counter.
  - POLL: repeatedly read RX occupancy until the returned value is >= TOTAL.
  - RX_DRAIN: read DRR TOTAL times. Discard the first 1+ADDR_BYTES+DUMMY bytes. Data byte k is stored in word k/4 at bits [8*(k%4)+7 : 8*(k%4)] (little-endian).
  - FILL_DONE: write the tag; set valid=1 unless a flush arrived during the fill. Go to RESPOND.
  - RESPOND: cpu_hs_ready_o=1 for exactly one cycle; cpu_hs_data_o = line word selected by cpu_hs_addr_i; then go to IDLE.
- Hit latency: ready asserts 1 cycle after read is sampled in IDLE.
- Miss latency: (2 + TOTAL + polls + TOTAL) bus accesses plus 2 cycles.
- flush_i in IDLE or RESPOND: valid cleared on the next edge.
- flush_i mid-fill: latched as flush_pend. The fill completes and the CPU still receives data, but valid stays 0. flush_pend clears in FILL_DONE.
- flush_i and read in the same IDLE cycle: flush wins, so the read is treated as a miss.
- If cpu_hs_read_i drops before ready, the fill still completes (line becomes valid), no ready pulse is issued, and the FSM returns to IDLE.
- Reset mid-fill: immediate return to IDLE with valid=0. The SPI controller may be left inhibited; the next miss rewrites CR.
- Byte counter width is clog2(TOTAL+1). It must not wrap inside a phase.

Optional Feature:
SPI_FETCH_FAST_READ_EN
- Defined: command byte is 0x0B (3-byte) or 0x0C (4-byte); DUMMY=1; one extra 0x00 byte is sent after the address and its received byte is discarded.
- Undefined: commands 0x03/0x13, DUMMY=0.

Test Plan:
1. Reset, then read 0x00000104 (defaults, flash bytes 0x100..0x107 = 11..88). Bus writes: CR=4, DTR bytes 03,00,01,00 then 8×00, CR=0. Poll until 12; 12 DRR reads. Ready with data 0x88776655.
2. Follow-up read 0x00000100 after test 1: ready exactly 1 cycle after the request; data 0x44332211; no bus activity.
3. flush_i pulse, then read 0x100: full SPI sequence repeats. A flush mid-fill gives ready with correct data, and the next read 0x100 misses again.
4. ADDR_BYTES=4, read 0x01020300: DTR bytes 13,01,02,03,00 then data zeros; poll threshold 13.
5. Bus ready stalled 5 cycles per access: rd/wr, addr and data stay constant during the stall; result matches test 1.
6. Reset asserted while in POLL: all outputs 0 asynchronously; the next read 0x100 misses and performs the full sequence from CR=4.

Source files
------------

// File: rtl/spi_flash_fetch_ctrl.sv
// rtl/spi_flash_fetch_ctrl.sv - line-buffered SPI flash instruction fetch bridge
// Define SPI_FETCH_FAST_READ_EN to use fast-read commands with one dummy byte.
module spi_flash_fetch_ctrl #(
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned LINE_WORDS = 2,
  parameter logic [31:0] SPI_BASE   = 32'h10200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        cpu_hs_read_i,
  input  logic [31:0] cpu_hs_addr_i,
  output logic        cpu_hs_ready_o,
  output logic [31:0] cpu_hs_data_o,
  input  logic        bus_hs_ready_i,
  input  logic [31:0] bus_hs_data_i,
  output logic        bus_hs_rd_o,
  output logic        bus_hs_wr_o,
  output logic [31:0] bus_hs_addr_o,
  output logic [31:0] bus_hs_data_o,
  output logic        busy_o
);

`ifdef SPI_FETCH_FAST_READ_EN
  localparam int unsigned DUMMY = 1;
  localparam logic [7:0]  CMD   = (ADDR_BYTES == 4) ? 8'h0C : 8'h0B;
`else
  localparam int unsigned DUMMY = 0;
  localparam logic [7:0]  CMD   = (ADDR_BYTES == 4) ? 8'h13 : 8'h03;
`endif
  localparam int unsigned HDR   = 1 + ADDR_BYTES + DUMMY;
  localparam int unsigned TOTAL = HDR + 4 * LINE_WORDS;
  localparam int unsigned AW    = 8 * ADDR_BYTES;
  localparam int unsigned OFF   = $clog2(4 * LINE_WORDS);
  localparam int unsigned TW    = AW - OFF;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned IW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  if (TOTAL > FIFO_DEPTH) begin : g_fifo_check
    $error("spi_flash_fetch_ctrl: transaction length exceeds FIFO_DEPTH");
  end
  if (ADDR_BYTES != 3 && ADDR_BYTES != 4) begin : g_ab_check
    $error("spi_flash_fetch_ctrl: ADDR_BYTES must be 3 or 4");
  end
  if (LINE_WORDS < 1 || LINE_WORDS > 8 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_lw_check
    $error("spi_flash_fetch_ctrl: LINE_WORDS must be a power of two in 1..8");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SET_INH   = 3'd1;
  localparam logic [2:0] S_TX_FILL   = 3'd2;
  localparam logic [2:0] S_CLR_INH   = 3'd3;
  localparam logic [2:0] S_POLL      = 3'd4;
  localparam logic [2:0] S_RX_DRAIN  = 3'd5;
  localparam logic [2:0] S_FILL_DONE = 3'd6;
  localparam logic [2:0] S_RESPOND   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [AW-1:0] laddr_q, laddr_d;
  logic [31:0]   line_q [LINE_WORDS];
  logic [31:0]   line_d [LINE_WORDS];

  logic          hit;
  logic [7:0]    tx_byte;
  logic [31:0]   rx_k;
  logic [IW-1:0] rd_idx;
  logic          unused_addr;

  assign unused_addr = ^cpu_hs_addr_i;
  assign hit    = valid_q && !flush_i && (tag_q == cpu_hs_addr_i[AW-1:OFF]);
  assign rd_idx = (LINE_WORDS > 1) ? cpu_hs_addr_i[IW+1:2] : '0;
  assign rx_k   = 32'(cnt_q) - HDR;

  always_comb begin
    tx_byte = 8'h00;
    if (cnt_q == '0) begin
      tx_byte = CMD;
    end else if (32'(cnt_q) <= ADDR_BYTES) begin
      tx_byte = 8'(laddr_q >> (8 * (ADDR_BYTES - 32'(cnt_q))));
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    pend_d        = pend_q;
    tag_d         = tag_q;
    laddr_d       = laddr_q;
    line_d        = line_q;
    bus_hs_rd_o   = 1'b0;
    bus_hs_wr_o   = 1'b0;
    bus_hs_addr_o = 32'h0;
    bus_hs_data_o = 32'h0;
    if (flush_i && state_q != S_IDLE && state_q != S_RESPOND) pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) valid_d = 1'b0;
        if (cpu_hs_read_i) begin
          if (hit) begin
            state_d = S_RESPOND;
          end else begin
            laddr_d = {cpu_hs_addr_i[AW-1:OFF], {OFF{1'b0}}};
            valid_d = 1'b0;
            state_d = S_SET_INH;
          end
        end
      end
      S_SET_INH: begin
        bus_hs_wr_o   = 1'b1;
        bus_hs_addr_o = SPI_BASE;
        bus_hs_data_o = 32'h4;
        if (bus_hs_ready_i) begin
          cnt_d   = '0;
          state_d = S_TX_FILL;
        end
      end
      S_TX_FILL: begin
        bus_hs_wr_o   = 1'b1;
        bus_hs_addr_o = SPI_BASE + 32'h08;
        bus_hs_data_o = {24'h0, tx_byte};
        if (bus_hs_ready_i) begin
          if (cnt_q == CW'(TOTAL - 1)) begin
            cnt_d   = '0;
            state_d = S_CLR_INH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CLR_INH: begin
        bus_hs_wr_o   = 1'b1;
        bus_hs_addr_o = SPI_BASE;
        if (bus_hs_ready_i) begin
          cnt_d   = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        bus_hs_rd_o   = 1'b1;
        bus_hs_addr_o = SPI_BASE + 32'h14;
        if (bus_hs_ready_i && bus_hs_data_i >= 32'(TOTAL)) state_d = S_RX_DRAIN;
      end
      S_RX_DRAIN: begin
        bus_hs_rd_o   = 1'b1;
        bus_hs_addr_o = SPI_BASE + 32'h0C;
        if (bus_hs_ready_i) begin
          // Header echo bytes are dropped; data bytes pack little-endian.
          if (32'(cnt_q) >= HDR) line_d[IW'(rx_k >> 2)][8*rx_k[1:0] +: 8] = bus_hs_data_i[7:0];
          if (cnt_q == CW'(TOTAL - 1)) begin
            cnt_d   = '0;
            state_d = S_FILL_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FILL_DONE: begin
        tag_d   = laddr_q[AW-1:OFF];
        valid_d = !(pend_q || flush_i);
        pend_d  = 1'b0;
        state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (flush_i) valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      tag_q   <= '0;
      laddr_q <= '0;
      line_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      laddr_q <= laddr_d;
      line_q  <= line_d;
    end
  end

  assign cpu_hs_ready_o = (state_q == S_RESPOND) && cpu_hs_read_i;
  assign cpu_hs_data_o  = cpu_hs_ready_o ? line_q[rd_idx] : 32'h0;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_flash_fetch_ctrl.sv
// tb/tb_spi_flash_fetch_ctrl.sv - randomized bench with a line-buffer and SPI transaction model
`timescale 1ns/1ps
module tb_spi_flash_fetch_ctrl;
`ifdef SPI_FETCH_FAST_READ_EN
  localparam int DUMMY = 1;
  localparam logic [7:0] CMD3 = 8'h0B;
  localparam logic [7:0] CMD4 = 8'h0C;
`else
  localparam int DUMMY = 0;
  localparam logic [7:0] CMD3 = 8'h03;
  localparam logic [7:0] CMD4 = 8'h13;
`endif
  localparam logic [31:0] BASE = 32'h10200;
  localparam int LW = 2;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        flush [2];
  logic        rd    [2];
  logic [31:0] caddr [2];
  logic        brdy  [2];
  logic [31:0] brdata[2];
  logic        cready[2];
  logic [31:0] cdata [2];
  logic        brd   [2];
  logic        bwr   [2];
  logic [31:0] baddr [2];
  logic [31:0] bwdata[2];
  logic        busy  [2];

  logic        mvalid[2];
  logic [31:0] mline [2];
  logic [7:0]  dtr_seen[$];
  int errors = 0;
  int checks = 0;

  spi_flash_fetch_ctrl #(.ADDR_BYTES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .cpu_hs_read_i(rd[0]), .cpu_hs_addr_i(caddr[0]),
    .cpu_hs_ready_o(cready[0]), .cpu_hs_data_o(cdata[0]), .bus_hs_ready_i(brdy[0]), .bus_hs_data_i(brdata[0]),
    .bus_hs_rd_o(brd[0]), .bus_hs_wr_o(bwr[0]), .bus_hs_addr_o(baddr[0]), .bus_hs_data_o(bwdata[0]), .busy_o(busy[0]));

  spi_flash_fetch_ctrl #(.ADDR_BYTES(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .cpu_hs_read_i(rd[1]), .cpu_hs_addr_i(caddr[1]),
    .cpu_hs_ready_o(cready[1]), .cpu_hs_data_o(cdata[1]), .bus_hs_ready_i(brdy[1]), .bus_hs_data_i(brdata[1]),
    .bus_hs_rd_o(brd[1]), .bus_hs_wr_o(bwr[1]), .bus_hs_addr_o(baddr[1]), .bus_hs_data_o(bwdata[1]), .busy_o(busy[1]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h108) return 8'((a - 32'h100 + 1) * 32'h11);
    return 8'(a ^ (a >> 8) ^ (a >> 16) ^ (a >> 24) ^ 32'h5A);
  endfunction

  function automatic acc_t mk(input logic wr, input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
    acc_t e;
    e.wr = wr; e.addr = a; e.wdata = w; e.resp = r;
    return e;
  endfunction

  task automatic check_idle(input int d, input string name);
    chk(name, {busy[d], cready[d], cdata[d], brd[d], bwr[d], baddr[d], bwdata[d]}, '0);
  endtask

  task automatic pulse_flush(input int d);
    @(negedge clk); flush[d] = 1'b1; #1;
    check_idle(d, "flush_idle");
    @(negedge clk); flush[d] = 1'b0;
    mvalid[d] = 1'b0;
  endtask

  // One CPU fetch on instance d; negative *_at arguments disable that event.
  task automatic do_read(input int d, input logic [31:0] a, input int smin, input int smax, input bit flush_first,
                         input int flush_at, input int drop_at, input int rst_at,
                         input bit lit_en, input logic [31:0] lit_data);
    int ab, total, hdr, npoll;
    logic [31:0] amask, line, wexp;
    bit hit;
    acc_t q[$];
    acc_t e;
    ab    = 3 + d;
    total = 1 + ab + DUMMY + 4 * LW;
    hdr   = 1 + ab + DUMMY;
    amask = (ab == 4) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
    line  = a & amask & ~32'(4 * LW - 1);
    for (int b = 0; b < 4; b++) wexp[8*b +: 8] = flash_byte(((a & amask) & ~32'h3) + 32'(b));
    hit = mvalid[d] && (mline[d] == line) && !flush_first;
    dtr_seen.delete();

    @(negedge clk); rd[d] = 1'b1; caddr[d] = a; flush[d] = flush_first; brdy[d] = 1'b0; #1;
    check_idle(d, "req_idle");
    if (flush_first) mvalid[d] = 1'b0;
    if (hit) begin
      @(negedge clk); flush[d] = 1'b0; #1;
      chk("hit_ready", {busy[d], cready[d], brd[d], bwr[d], baddr[d], bwdata[d]}, {2'b11, 66'h0});
      chk("hit_data", cdata[d], wexp);
      if (lit_en) chk("hit_lit", cdata[d], lit_data);
      @(negedge clk); rd[d] = 1'b0; #1;
      check_idle(d, "hit_after");
      return;
    end

    q.push_back(mk(1'b1, BASE, 32'h4, 32'h0));
    for (int i = 0; i < total; i++) begin
      logic [7:0] tb;
      if (i == 0) tb = (ab == 4) ? CMD4 : CMD3;
      else if (i <= ab) tb = 8'(line >> (8 * (ab - i)));
      else tb = 8'h00;
      q.push_back(mk(1'b1, BASE + 32'h08, {24'h0, tb}, 32'h0));
    end
    q.push_back(mk(1'b1, BASE, 32'h0, 32'h0));
    npoll = $urandom_range(0, 3);
    for (int i = 0; i < npoll; i++)
      q.push_back(mk(1'b0, BASE + 32'h14, 32'h0, (i == npoll - 1) ? 32'(total - 1) : 32'($urandom_range(0, total - 1))));
    q.push_back(mk(1'b0, BASE + 32'h14, 32'h0, $urandom_range(0, 1) ? 32'(total) : 32'($urandom_range(total, 16))));
    for (int i = 0; i < total; i++)
      q.push_back(mk(1'b0, BASE + 32'h0C, 32'h0,
                     (i < hdr) ? 32'($urandom_range(0, 255)) : {24'h0, flash_byte(line + 32'(i - hdr))}));

    for (int k = 0; k < q.size(); k++) begin
      int s;
      s = $urandom_range(smin, smax);
      e = q[k];
      for (int c = 0; c <= s; c++) begin
        @(negedge clk);
        flush[d] = (k == flush_at && c == 0);
        if (k == drop_at) rd[d] = 1'b0;
        brdy[d]   = (c == s);
        brdata[d] = (!e.wr && c == s) ? e.resp : $urandom;
        #1;
        chk("bus_access", {brd[d], bwr[d], baddr[d], bwdata[d]}, {~e.wr, e.wr, e.addr, e.wdata});
        chk("fill_busy", {busy[d], cready[d], cdata[d]}, {2'b10, 32'h0});
        if (k == rst_at) begin
          rst_n = 1'b0; #1;
          check_idle(d, "rst_outputs");
          mvalid[0] = 1'b0; mvalid[1] = 1'b0;
          @(negedge clk); rst_n = 1'b1; rd[d] = 1'b0; brdy[d] = 1'b0; flush[d] = 1'b0;
          return;
        end
      end
      if (e.wr && e.addr == BASE + 32'h08) dtr_seen.push_back(bwdata[d][7:0]);
    end

    @(negedge clk); flush[d] = 1'b0; brdy[d] = 1'b0; #1;
    chk("fill_done", {busy[d], cready[d], cdata[d], brd[d], bwr[d], baddr[d], bwdata[d]}, {2'b10, 98'h0});
    @(negedge clk); #1;
    chk("respond", {busy[d], cready[d], brd[d], bwr[d], baddr[d], bwdata[d]}, {1'b1, drop_at < 0, 66'h0});
    if (drop_at < 0) begin
      chk("miss_data", cdata[d], wexp);
      if (lit_en) chk("miss_lit", cdata[d], lit_data);
    end
    mvalid[d] = (flush_at < 0);
    mline[d]  = line;
    @(negedge clk); rd[d] = 1'b0; #1;
    check_idle(d, "miss_after");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 0; rd[d] = 0; caddr[d] = 0; brdy[d] = 0; brdata[d] = 0; mvalid[d] = 0; mline[d] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_idle(0, "reset3");
    check_idle(1, "reset4");
    @(negedge clk); rst_n = 1'b1;

    do_read(0, 32'h104, 0, 0, 0, -1, -1, -1, 1, 32'h8877_6655);
    chk("t1_dtr_hdr", {dtr_seen[0], dtr_seen[1], dtr_seen[2], dtr_seen[3]}, {CMD3, 8'h00, 8'h01, 8'h00});
    chk("t1_dtr_cnt", dtr_seen.size(), 12 + DUMMY);
    do_read(0, 32'h100, 0, 0, 0, -1, -1, -1, 1, 32'h4433_2211);

    pulse_flush(0);
    do_read(0, 32'h100, 0, 1, 0, -1, -1, -1, 1, 32'h4433_2211);
    pulse_flush(0);
    do_read(0, 32'h104, 0, 1, 0, 7, -1, -1, 1, 32'h8877_6655);
    do_read(0, 32'h100, 0, 1, 0, -1, -1, -1, 1, 32'h4433_2211);

    do_read(1, 32'h0102_0300, 0, 1, 0, -1, -1, -1, 0, 32'h0);
    chk("t4_dtr_hdr", {dtr_seen[0], dtr_seen[1], dtr_seen[2], dtr_seen[3], dtr_seen[4]},
        {CMD4, 8'h01, 8'h02, 8'h03, 8'h00});
    chk("t4_dtr_cnt", dtr_seen.size(), 13 + DUMMY);

    pulse_flush(0);
    do_read(0, 32'h104, 5, 5, 0, -1, -1, -1, 1, 32'h8877_6655);

    do_read(0, 32'h200, 0, 1, 0, -1, 3, -1, 0, 32'h0);
    do_read(0, 32'h204, 0, 0, 0, -1, -1, -1, 0, 32'h0);
    do_read(0, 32'h204, 0, 1, 1, -1, -1, -1, 0, 32'h0);

    pulse_flush(0);
    do_read(0, 32'h100, 0, 0, 0, -1, -1, 12 + DUMMY + 2, 0, 32'h0);
    do_read(0, 32'h100, 0, 1, 0, -1, -1, -1, 1, 32'h4433_2211);

    for (int it = 0; it < 40; it++) begin
      int d, r;
      logic [31:0] a;
      logic [31:0] pool3 [4];
      logic [31:0] pool4 [4];
      pool3 = '{32'h100, 32'h108, 32'hABCDE8, 32'h0};
      pool4 = '{32'h0102_0300, 32'h8000_0008, 32'hFFFF_FFF8, 32'h100};
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      a = (d == 0) ? ({$urandom} & 32'hFF00_0000) | pool3[$urandom_range(0, 3)] : pool4[$urandom_range(0, 3)];
      a = a | 32'($urandom_range(0, 7));
      if (r == 0) pulse_flush(d);
      do_read(d, a, 0, $urandom_range(0, 2), r == 1, (r == 2) ? $urandom_range(0, 20) : -1,
              (r == 3) ? $urandom_range(1, 20) : -1, -1, 0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
